// File: rtl/game_pkg.sv
// Shared types and constants for the match controller: state encoding,
// winner codes and the goal-hold counter width.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_GOAL_HOLD = 3'd3,
    ST_OVER      = 3'd4,
    ST_OVERTIME  = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int unsigned HOLD_W = 4;

  function automatic logic [1:0] judge(input logic t1_ahead, input logic t2_ahead);
    if (t1_ahead) return WIN_T1;
    if (t2_ahead) return WIN_T2;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Button/goal pulse inputs and display-side outputs of the match controller.
// master = pulse sources and display consumer, slave = the controller.
interface match_controller_if #(
  parameter int unsigned TIME_W  = 8,
  parameter int unsigned SCORE_W = 4
) ();
  logic               start_btn;
  logic               pause_btn;
  logic               goal_team1;
  logic               goal_team2;
  logic               game_on;
  logic               game_over;
  logic               ball_reset;
  logic [TIME_W-1:0]  time_left;
  logic [SCORE_W-1:0] team1_score;
  logic [SCORE_W-1:0] team2_score;
  logic [1:0]         winner;
  logic [2:0]         state;

  modport master (
    output start_btn, pause_btn, goal_team1, goal_team2,
    input  game_on, game_over, ball_reset, time_left,
    input  team1_score, team2_score, winner, state
  );

  modport slave (
    input  start_btn, pause_btn, goal_team1, goal_team2,
    output game_on, game_over, ball_reset, time_left,
    output team1_score, team2_score, winner, state
  );
endinterface

// File: rtl/sec_prescaler.sv
// Game-second prescaler: counts 0..CLK_FREQ-1 while enabled and flags the
// last count; clr forces the count back to zero.
module sec_prescaler #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q;

  // tick is not masked by clr so a goal on the final count still ages the timer
  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/match_controller.sv
// Match lifecycle controller: start/pause, countdown, saturating scores,
// post-goal hold and winner report. Overtime is enabled by MATCH_OVERTIME_EN.
module match_controller
  import game_pkg::*;
#(
  parameter int unsigned CLK_FREQ          = 50000000,
  parameter int unsigned MATCH_SECONDS     = 180,
  parameter int unsigned TIME_W            = 8,
  parameter int unsigned SCORE_W           = 4,
  parameter int unsigned GOAL_HOLD_SECONDS = 2,
  parameter int unsigned SCORE_LIMIT       = 0
) (
  input  logic               clk,
  input  logic               rst,
  match_controller_if.slave  bus
);
  localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(MATCH_SECONDS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GOAL_HOLD_SECONDS - 1);

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               ball_reset_q, ball_reset_d;
  logic               game_on_q, game_over_q;
  logic               tick, presc_en, presc_clr;
  logic               g1, g2, time_end;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  assign g1       = bus.goal_team1;
  assign g2       = bus.goal_team2;
  assign presc_en = (state_q == ST_PLAYING) || (state_q == ST_GOAL_HOLD);
  assign time_end = tick && (time_q <= TIME_W'(1));

  sec_prescaler #(.CLK_FREQ(CLK_FREQ)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    winner_d     = winner_q;
    hold_d       = hold_q;
    ball_reset_d = 1'b0;
    presc_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_clr = 1'b1;
        if (bus.start_btn) begin
          state_d      = ST_PLAYING;
          time_d       = TIME_INIT;
          score1_d     = '0;
          score2_d     = '0;
          winner_d     = WIN_NONE;
          ball_reset_d = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (g1) score1_d = sat_inc(score1_q);
        if (g2) score2_d = sat_inc(score2_q);
        if (tick && (time_q != '0)) time_d = time_q - TIME_W'(1);
        // Timer expiry wins over goal hold; the winner sees this cycle's goals
        if (time_end) begin
`ifdef MATCH_OVERTIME_EN
          if (score1_d == score2_d) begin
            state_d = ST_OVERTIME;
          end else begin
            state_d  = ST_OVER;
            winner_d = judge(score1_d > score2_d, score2_d > score1_d);
          end
`else
          state_d  = ST_OVER;
          winner_d = judge(score1_d > score2_d, score2_d > score1_d);
`endif
        end else if ((g1 || g2) && (SCORE_LIMIT != 0) &&
                     ((32'(score1_d) >= SCORE_LIMIT) || (32'(score2_d) >= SCORE_LIMIT))) begin
          state_d  = ST_OVER;
          winner_d = judge(score1_d > score2_d, score2_d > score1_d);
        end else if (g1 || g2) begin
          state_d   = ST_GOAL_HOLD;
          hold_d    = '0;
          presc_clr = 1'b1;
        end else if (bus.pause_btn) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (bus.pause_btn) state_d = ST_PLAYING;
      end
      ST_GOAL_HOLD: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d      = ST_PLAYING;
            ball_reset_d = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_OVER: begin
        presc_clr = 1'b1;
        if (bus.start_btn) begin
          state_d  = ST_IDLE;
          time_d   = TIME_INIT;
          score1_d = '0;
          score2_d = '0;
          winner_d = WIN_NONE;
        end
      end
`ifdef MATCH_OVERTIME_EN
      ST_OVERTIME: begin
        if (g1 || g2) begin
          if (g1) score1_d = sat_inc(score1_q);
          if (g2) score2_d = sat_inc(score2_q);
          state_d  = ST_OVER;
          winner_d = (g1 && g2) ? WIN_DRAW : (g1 ? WIN_T1 : WIN_T2);
        end
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        presc_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      time_q       <= TIME_INIT;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= WIN_NONE;
      hold_q       <= '0;
      ball_reset_q <= 1'b0;
      game_on_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      hold_q       <= hold_d;
      ball_reset_q <= ball_reset_d;
      game_on_q    <= (state_d == ST_PLAYING) || (state_d == ST_OVERTIME);
      game_over_q  <= (state_d == ST_OVER);
    end
  end

  assign bus.game_on     = game_on_q;
  assign bus.game_over   = game_over_q;
  assign bus.ball_reset  = ball_reset_q;
  assign bus.time_left   = time_q;
  assign bus.team1_score = score1_q;
  assign bus.team2_score = score2_q;
  assign bus.winner      = winner_q;
  assign bus.state       = state_q;
endmodule
